// File: rtl/max_search_81x81_pkg.sv
// Shared face-detection definitions: correlation-map geometry, bus widths
// and the max-search state encoding (also used by the threshold stage).
package max_search_81x81_pkg;

  localparam int OM_MAP_W    = 81;
  localparam int OM_ROW_LAST = 78;
  localparam int OM_COL_LAST = 79;
  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 32;

  // Highest address a scan may issue with the default geometry.
  localparam int OM_ADDR_MAX = OM_ROW_LAST * OM_MAP_W + OM_COL_LAST;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scanState_t;

endpackage

// File: rtl/max_search_81x81_om_scan_addr_gen.sv
// Row/column scan counter for the OM read port. The address is kept as a
// running value (+1 per column, +MAP_W-COL_LAST on a row wrap), so no
// multiplier is needed and the skipped right-hand columns are never issued.
module om_scan_addr_gen
  import max_search_81x81_pkg::*;
#(
  parameter int MAP_W    = OM_MAP_W,
  parameter int ROW_LAST = OM_ROW_LAST,
  parameter int COL_LAST = OM_COL_LAST
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iClear,
  input  logic              iLoad,
  input  logic              iAdvance,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oLast
);

  localparam int ROW_W = $clog2(ROW_LAST + 1);
  localparam int COL_W = $clog2(COL_LAST + 1);
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(MAP_W - COL_LAST);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             rowEnd;
  logic             colEnd;

  // End-of-row / end-of-scan detection
  always_comb begin
    rowEnd = (row == ROW_W'(ROW_LAST));
    colEnd = (col == COL_W'(COL_LAST));
    oLast  = rowEnd && colEnd;
  end

  // Counters and address; holds on the last address until reloaded
  always_ff @(posedge iClk) begin
    if (!iReset_n || iClear || iLoad) begin
      row   <= '0;
      col   <= '0;
      oAddr <= '0;
    end else if (iAdvance && !oLast) begin
      if (colEnd) begin
        col   <= '0;
        row   <= row + ROW_W'(1);
        oAddr <= oAddr + WRAP_STEP;
      end else begin
        col   <= col + COL_W'(1);
        oAddr <= oAddr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/max_search_81x81.sv
// Scans the correlation map in OM and reports the largest value and its
// address. Ties keep the earliest address.
//
// state | meaning
// IDLE  | waiting for iStart
// SCAN  | issuing one OM address per cycle
// DRAIN | last sample in flight, final compare
// DONE  | result valid, oOutput_ready pulse
module max_search_81x81
  import max_search_81x81_pkg::*;
#(
  parameter int MAP_W    = OM_MAP_W,
  parameter int ROW_LAST = OM_ROW_LAST,
  parameter int COL_LAST = OM_COL_LAST
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic              iFinish,
  input  logic [DATA_W-1:0] iData_from_OM,
  output logic [ADDR_W-1:0] oAddr_OM,
  output logic [DATA_W-1:0] oMax_val,
  output logic [ADDR_W-1:0] oPosition,
  output logic              oOutput_ready,
  output logic              oBusy
);

  scanState_t        state;
  scanState_t        stateNext;
  logic              clr;
  logic              startAccept;
  logic              advance;
  logic              addrLast;
  logic              pVal;
  logic [ADDR_W-1:0] pAddr;
  logic              firstPend;
  logic [DATA_W-1:0] runMax;
  logic [ADDR_W-1:0] runPos;
  logic              takeSample;
  logic [DATA_W-1:0] maxNext;
  logic [ADDR_W-1:0] posNext;

  assign clr = !iReset_n || iFinish;

  om_scan_addr_gen #(
    .MAP_W    (MAP_W),
    .ROW_LAST (ROW_LAST),
    .COL_LAST (COL_LAST)
  ) uAddrGen (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iClear   (iFinish),
    .iLoad    (startAccept),
    .iAdvance (advance),
    .oAddr    (oAddr_OM),
    .oLast    (addrLast)
  );

  // State register; reset and iFinish override every transition
  always_ff @(posedge iClk) begin
    if (clr) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iStart)   stateNext = SCAN;
      SCAN:    if (addrLast) stateNext = DRAIN;
      DRAIN:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    startAccept   = (state == IDLE) && iStart && !iFinish;
    advance       = (state == SCAN);
    oOutput_ready = (state == DONE);
    oBusy         = (state != IDLE);
  end

  // Pair each returned sample with the address issued one cycle earlier
  always_ff @(posedge iClk) begin
    if (clr) begin
      pVal  <= 1'b0;
      pAddr <= '0;
    end else begin
      pVal  <= (state == SCAN);
      pAddr <= oAddr_OM;
    end
  end

  // Candidate update: first sample always loads, later ones only if strictly larger
  always_comb begin
    takeSample = pVal && (firstPend || (iData_from_OM > runMax));
    maxNext    = takeSample ? iData_from_OM : runMax;
    posNext    = takeSample ? pAddr : runPos;
  end

  // Running maximum tracker
  always_ff @(posedge iClk) begin
    if (clr) begin
      firstPend <= 1'b0;
      runMax    <= '0;
      runPos    <= '0;
    end else if (startAccept) begin
      firstPend <= 1'b1;
    end else if (pVal) begin
      firstPend <= 1'b0;
      runMax    <= maxNext;
      runPos    <= posNext;
    end
  end

  // Result registers load with the final compare so they are valid during DONE
  always_ff @(posedge iClk) begin
    if (clr) begin
      oMax_val  <= '0;
      oPosition <= '0;
    end else if (state == DRAIN) begin
      oMax_val  <= maxNext;
      oPosition <= posNext;
    end
  end

endmodule

// File: doc/max_search_81x81.md
MAX_SEARCH_81X81 -- requirements
Module: max_search_81x81

Interface
REQ-001 SHALL have parameter MAP_W, default 81: width of the correlation map held in OM, in entries per row.
REQ-002 SHALL have parameter ROW_LAST, default 78: last row scanned; leaves 2 rows below for the downstream +162 read.
REQ-003 SHALL have parameter COL_LAST, default 79: last column scanned; leaves 1 column for the downstream +1 read.
REQ-004 SHALL have port iClk, input, 1 bit: single clock; all logic samples on its rising edge.
REQ-005 SHALL have port iReset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port iStart, input, 1 bit: one-cycle pulse that starts one scan of OM.
REQ-007 SHALL have port iFinish, input, 1 bit: synchronous abort and clear, with the same effect as reset.
REQ-008 SHALL have port iData_from_OM, input, 32 bits: OM read data, valid 1 cycle after oAddr_OM.
REQ-009 SHALL have port oAddr_OM, output, 13 bits: OM read address.
REQ-010 SHALL have port oMax_val, output, 32 bits: maximum value found; feeds the threshold stage's iMax_val.
REQ-011 SHALL have port oPosition, output, 13 bits: OM address of that maximum; feeds iPosition.
REQ-012 SHALL have port oOutput_ready, output, 1 bit: one-cycle pulse marking oMax_val/oPosition valid; feeds iInput_ready.
REQ-013 SHALL have port oBusy, output, 1 bit: high from start acceptance through the oOutput_ready cycle.

Function
REQ-014 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-015 IDLE: SHALL accept iStart=1, clear row/col counters, set oAddr_OM=0 and go to SCAN; oBusy SHALL go high on the same edge.
REQ-016 SCAN: SHALL issue one address per cycle in row-major order over rows 0..ROW_LAST and cols 0..COL_LAST, with oAddr_OM = row*MAP_W + col (13-bit unsigned).
REQ-017 SCAN: at col==COL_LAST the next address SHALL be col=0, row+1; this skips cols COL_LAST+1..MAP_W-1.
REQ-018 SCAN SHALL go to DRAIN after issuing (ROW_LAST, COL_LAST); oAddr_OM SHALL then hold that last address.
REQ-019 A 1-cycle valid/address pipeline SHALL pair each returned sample with its issued address.
REQ-020 The first sample of a scan SHALL load the running max and position unconditionally.
REQ-021 Each later sample SHALL replace the running max only if strictly greater, unsigned 32-bit; on ties the earliest address wins.
REQ-022 DRAIN SHALL consume the final sample and then go to DONE.
REQ-023 DONE SHALL drive oMax_val/oPosition from the running registers, pulse oOutput_ready for exactly 1 cycle and return to IDLE; oBusy SHALL drop on that same edge.
REQ-024 oMax_val and oPosition SHALL hold their values until the next DONE, reset or iFinish.
REQ-025 Latency: 80*79 = 6320 samples; oOutput_ready SHALL be high in cycle 6322 after the iStart-accept edge, with the first address presented in cycle 1.
REQ-026 iStart while oBusy=1 SHALL be ignored; no restart and no queuing.
REQ-027 iStart in the same cycle as DONE SHALL be ignored; it is accepted only from IDLE.
REQ-028 iFinish=1 SHALL dominate iStart and every state transition.
REQ-029 Address arithmetic SHALL never exceed ROW_LAST*MAP_W+COL_LAST = 6397 and SHALL never wrap.

Reset
REQ-030 On iReset_n=0 or iFinish=1 at a clock edge, the block SHALL enter IDLE with oAddr_OM=0, oMax_val=0, oPosition=0, oOutput_ready=0, oBusy=0, and counters and pipeline valid cleared.
REQ-031 Reset or iFinish mid-scan SHALL abort with no oOutput_ready pulse; the next iStart SHALL begin a fresh scan at address 0.

Structure
REQ-032 MAP_W, ROW_LAST, COL_LAST, the 13-bit address width, the 32-bit data width and the state encoding SHALL live in the shared face-detection package, also used by the threshold stage.
REQ-033 The row/col counter with wrap and address generation SHALL be a single sub-module, om_scan_addr_gen; compare/track logic and FSM SHALL stay in the top.

Verification
REQ-034 All-zero OM, iStart -> oOutput_ready in cycle 6322, oMax_val=0, oPosition=0, oBusy high for exactly cycles 1..6322.
REQ-035 OM[5000]=0x04E66667, all others 1 -> oMax_val=0x04E66667, oPosition=5000 (row 61, col 59).
REQ-036 OM[100]=OM[4000]=0xFFFFFFFF, tie -> oPosition=100; and OM[80]=0x7FFFFFFF (col 80, skipped) -> not reported; no address in 80, 161, 6398..6560 is ever issued.
REQ-037 iStart again at cycle 3000 of a scan -> ignored, single result at cycle 6322; iStart in the DONE cycle -> ignored, oBusy=0 next cycle.
REQ-038 iFinish at cycle 2000, then iStart at cycle 2005 -> no pulse from the first scan, outputs 0, second scan's oOutput_ready 6322 cycles after cycle 2005.
REQ-039 iReset_n=0 for 1 cycle mid-SCAN -> all outputs at REQ-030 values on the next cycle, FSM in IDLE.
